// File: rtl/arcfour_ksa.sv
// RC4 key-scheduling engine: fills an external 256x8 S-box with S[i]=i,
// then runs the KSA swap loop with a 3-byte key. It exposes debug taps for the FSM.
module arcfour_ksa (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] key,
    input  logic        start_sig,
    output logic        arcfour_finished,
    input  logic [7:0]  ram_out,
    output logic        write_enable,
    output logic [7:0]  ram_in,
    output logic [7:0]  address,
    output logic [2:0]  state_tap,
    output logic [1:0]  fTap,
    output logic [7:0]  iTap,
    output logic [7:0]  jTap,
    output logic [7:0]  siTap,
    output logic [7:0]  sjTap,
    output logic        readTap,
    output logic        writeTap,
    output logic        fStartTap
);

    localparam int unsigned DW = 8;
    localparam int unsigned KW = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        RD_I = 3'd2,
        RD_J = 3'd3,
        WR_I = 3'd4,
        WR_J = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] i, i_nxt;
    logic [DW-1:0] j, j_nxt;
    logic [DW-1:0] si, si_nxt;
    logic [DW-1:0] sj, sj_nxt;
    logic [KW-1:0] kidx, kidx_nxt;
    logic          fstart, fstart_nxt;
    logic [DW-1:0] key_byte;
    logic [DW-1:0] j_sum;

    // kidx tracks i mod 3 without a divider
    always_comb begin
        case (kidx)
            2'd0:    key_byte = key[23:16];
            2'd1:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
        j_sum = j + ram_out + key_byte;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            si     <= '0;
            sj     <= '0;
            kidx   <= '0;
            fstart <= 1'b0;
        end else begin
            state  <= state_nxt;
            i      <= i_nxt;
            j      <= j_nxt;
            si     <= si_nxt;
            sj     <= sj_nxt;
            kidx   <= kidx_nxt;
            fstart <= fstart_nxt;
        end
    end

    // Next state, datapath updates and RAM port drive
    always_comb begin
        state_nxt    = state;
        i_nxt        = i;
        j_nxt        = j;
        si_nxt       = si;
        sj_nxt       = sj;
        kidx_nxt     = kidx;
        fstart_nxt   = 1'b0;
        address      = '0;
        ram_in       = '0;
        write_enable = 1'b0;
        case (state)
            IDLE: begin
                if (start_sig) begin
                    i_nxt     = '0;
                    j_nxt     = '0;
                    kidx_nxt  = '0;
                    state_nxt = INIT;
                end
            end
            INIT: begin
                address      = i;
                ram_in       = i;
                write_enable = 1'b1;
                if (i == 8'hFF) begin
                    i_nxt      = '0;
                    j_nxt      = '0;
                    kidx_nxt   = '0;
                    fstart_nxt = 1'b1;
                    state_nxt  = RD_I;
                end else begin
                    i_nxt = i + 8'd1;
                end
            end
            RD_I: begin
                address   = i;
                state_nxt = RD_J;
            end
            RD_J: begin
                si_nxt    = ram_out;
                j_nxt     = j_sum;
                address   = j_sum;
                state_nxt = WR_I;
            end
            WR_I: begin
                sj_nxt       = ram_out;
                address      = i;
                ram_in       = ram_out;
                write_enable = 1'b1;
                state_nxt    = WR_J;
            end
            WR_J: begin
                address      = j;
                ram_in       = si;
                write_enable = 1'b1;
                if (i == 8'hFF) begin
                    state_nxt = DONE;
                end else begin
                    i_nxt     = i + 8'd1;
                    kidx_nxt  = (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                    state_nxt = RD_I;
                end
            end
            DONE: begin
                if (!start_sig) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Debug taps
    always_comb begin
        case (state)
            IDLE:    fTap = 2'd0;
            INIT:    fTap = 2'd1;
            DONE:    fTap = 2'd3;
            default: fTap = 2'd2;
        endcase
    end

    assign arcfour_finished = (state == DONE);
    assign state_tap        = state;
    assign iTap             = i;
    assign jTap             = j;
    assign siTap            = si;
    assign sjTap            = sj;
    assign readTap          = (state == RD_I) || (state == RD_J);
    assign writeTap         = write_enable;
    assign fStartTap        = fstart;

endmodule

// File: tb/tb_arcfour_ksa.sv
// Self-checking bench for arcfour_ksa: behavioural S-RAM, reference KSA
// scoreboard, timing, start handshake and mid-run reset scenarios.
module tb_arcfour_ksa;

    logic        clk;
    logic        reset;
    logic [23:0] key;
    logic        start_sig;
    logic        arcfour_finished;
    logic [7:0]  ram_out;
    logic        write_enable;
    logic [7:0]  ram_in;
    logic [7:0]  address;
    logic [2:0]  state_tap;
    logic [1:0]  fTap;
    logic [7:0]  iTap, jTap, siTap, sjTap;
    logic        readTap, writeTap, fStartTap;

    logic [7:0]  mem [256];
    logic [7:0]  exp_q [$];
    logic [15:0] init_q [$];
    int          checks;
    int          failures;

    arcfour_ksa dut (
        .clk(clk), .reset(reset), .key(key), .start_sig(start_sig),
        .arcfour_finished(arcfour_finished), .ram_out(ram_out),
        .write_enable(write_enable), .ram_in(ram_in), .address(address),
        .state_tap(state_tap), .fTap(fTap), .iTap(iTap), .jTap(jTap),
        .siTap(siTap), .sjTap(sjTap), .readTap(readTap), .writeTap(writeTap),
        .fStartTap(fStartTap)
    );

    always #5 clk = ~clk;

    // S-RAM: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        if (write_enable) mem[address] <= ram_in;
        ram_out <= mem[address];
    end

    task automatic compute_ref(input logic [23:0] k);
        int s [256];
        int jj;
        int t;
        int kb;
        for (int n = 0; n < 256; n++) s[n] = n;
        jj = 0;
        for (int n = 0; n < 256; n++) begin
            kb = (n % 3 == 0) ? int'(k[23:16]) : (n % 3 == 1) ? int'(k[15:8]) : int'(k[7:0]);
            jj = (jj + s[n] + kb) % 256;
            t = s[n]; s[n] = s[jj]; s[jj] = t;
        end
        for (int n = 0; n < 256; n++) exp_q.push_back(8'(s[n]));
    endtask

    task automatic run_ksa(input logic [23:0] k, input bit drop_start);
        int          cycles;
        int          fstart_cnt;
        int          viol;
        bit          done_seen;
        logic [15:0] w;
        logic [7:0]  e;
        exp_q.delete();
        init_q.delete();
        compute_ref(k);
        for (int n = 0; n < 256; n++) init_q.push_back({8'(n), 8'(n)});
        @(negedge clk);
        key = k;
        start_sig = 1'b1;
        cycles = 0; fstart_cnt = 0; viol = 0; done_seen = 1'b0;
        while (!done_seen && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
            if (drop_start && cycles == 600) start_sig = 1'b0;
            if (write_enable && (state_tap == 3'd0 || state_tap == 3'd2 ||
                                 state_tap == 3'd3 || state_tap == 3'd6)) viol++;
            if (readTap && writeTap) viol++;
            if (writeTap !== write_enable) viol++;
            if (fStartTap) fstart_cnt++;
            if (write_enable && state_tap == 3'd1) begin
                if (init_q.size() == 0) begin
                    viol++;
                end else begin
                    w = init_q.pop_front();
                    checks++;
                    if ({address, ram_in} !== w) begin
                        failures++;
                        $display("FAIL init_write got addr/data=%h expected %h", {address, ram_in}, w);
                    end
                end
            end
            if (arcfour_finished) done_seen = 1'b1;
        end
        checks++;
        if (!done_seen || cycles != 1281) begin
            failures++;
            $display("FAIL run_latency done=%0b cycles=%0d expected 1281", done_seen, cycles);
        end
        checks++;
        if (fstart_cnt != 1) begin
            failures++;
            $display("FAIL fstart_pulse count=%0d expected 1", fstart_cnt);
        end
        checks++;
        if (viol != 0 || init_q.size() != 0) begin
            failures++;
            $display("FAIL protocol violations=%0d unmatched_init=%0d expected 0/0", viol, init_q.size());
        end
        init_q.delete();
        if (!drop_start) begin
            repeat (3) begin @(posedge clk); #1; end
            checks++;
            if (arcfour_finished !== 1'b1 || state_tap !== 3'd6) begin
                failures++;
                $display("FAIL done_hold finished=%0b state=%0d expected 1/6", arcfour_finished, state_tap);
            end
            start_sig = 1'b0;
        end
        @(posedge clk); #1;
        checks++;
        if (arcfour_finished !== 1'b0 || state_tap !== 3'd0) begin
            failures++;
            $display("FAIL return_idle finished=%0b state=%0d expected 0/0", arcfour_finished, state_tap);
        end
        for (int a = 0; a < 256; a++) begin
            e = exp_q.pop_front();
            checks++;
            if (mem[a] !== e) begin
                failures++;
                $display("FAIL sbox[%0d] got %h expected %h (key %h)", a, mem[a], e, k);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (state_tap !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got %0d expected 0", state_tap);
        end
        checks++;
        if ({arcfour_finished, write_enable, ram_in, address, fTap, iTap, jTap, siTap, sjTap,
             readTap, writeTap, fStartTap} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got we=%0b addr=%h i=%h j=%h expected all zero",
                     write_enable, address, iTap, jTap);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (state_tap !== 3'd0) begin
            failures++;
            $display("FAIL idle_no_start got state %0d expected 0", state_tap);
        end
    endtask

    task automatic test_key_zero();
        run_ksa(24'h000000, 1'b0);
    endtask

    task automatic test_key_010203();
        run_ksa(24'h010203, 1'b0);
    endtask

    task automatic test_start_drop();
        run_ksa(24'h010203, 1'b1);
        run_ksa(24'h010203, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        key = 24'hA55AC3;
        start_sig = 1'b1;
        repeat (700) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (state_tap !== 3'd0) begin
            failures++;
            $display("FAIL midrun_reset_state got %0d expected 0", state_tap);
        end
        checks++;
        if ({arcfour_finished, write_enable, ram_in, address, fTap, iTap, jTap, siTap, sjTap,
             readTap, writeTap, fStartTap} !== '0) begin
            failures++;
            $display("FAIL midrun_reset_outputs got we=%0b addr=%h i=%h j=%h expected all zero",
                     write_enable, address, iTap, jTap);
        end
        @(negedge clk);
        start_sig = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        run_ksa(24'hA55AC3, 1'b0);
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        key = '0;
        start_sig = 1'b0;
        checks = 0;
        failures = 0;
        test_reset();
        test_key_zero();
        test_key_010203();
        test_start_drop();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
